imm_pipe_stage: RTL and testbench

IMM_PIPE_STAGE -- requirements
Module: imm_pipe_stage

---
 rtl/imm_pipe_stage_pkg.sv | 22 ++
 rtl/imm_pipe_stage_field.sv | 55 +++++
 rtl/imm_pipe_stage.sv | 135 +++++++++++++
 tb/tb_imm_pipe_stage.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/imm_pipe_stage_pkg.sv
`default_nettype none
// ============================================================================
// imm_pipe_stage_pkg : immediate-mode encodings, prefix FSM state, widths
// Rev 1.0
// ============================================================================
package imm_pipe_stage_pkg;

    localparam logic [2:0] IMM_U8  = 3'b000;
    localparam logic [2:0] IMM_S6  = 3'b001;
    localparam logic [2:0] IMM_U3  = 3'b010;
    localparam logic [2:0] IMM_S5  = 3'b011;
    localparam logic [2:0] IMM_PFX = 3'b100;

    localparam int PFX_W = 12;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_ARMED = 1'b1
    } pfx_state_e;

endpackage
`default_nettype wire

// File: rtl/imm_pipe_stage_field.sv
`default_nettype none
// ============================================================================
// imm_field_extract : combinational immediate field decode and extension
// Rev 1.0
// ============================================================================
module imm_field_extract
    import imm_pipe_stage_pkg::*;
#(
    parameter int IMM_W     = 16,
    parameter int PREFIX_EN = 1
) (
    input  logic [PFX_W-1:0] instr_lo_i,
    input  logic [2:0]       imm_src_i,
    output logic [3:0]       raw_lo_o,
    output logic [IMM_W-1:0] ext_o,
    output logic             is_pfx_o,
    output logic             illegal_o
);

    // raw_lo_o is the low nibble of the unextended field, used to build prefixed values
    always_comb begin
        raw_lo_o  = 4'd0;
        ext_o     = '0;
        is_pfx_o  = 1'b0;
        illegal_o = 1'b0;
        case (imm_src_i)
            IMM_U8: begin
                raw_lo_o = instr_lo_i[7:4];
                ext_o    = IMM_W'(instr_lo_i[11:4]);
            end
            IMM_S6: begin
                raw_lo_o = instr_lo_i[3:0];
                ext_o    = IMM_W'($signed(instr_lo_i[5:0]));
            end
            IMM_U3: begin
                raw_lo_o = {1'b0, instr_lo_i[5:3]};
                ext_o    = IMM_W'(instr_lo_i[5:3]);
            end
            IMM_S5: begin
                raw_lo_o = instr_lo_i[3:0];
                ext_o    = IMM_W'($signed(instr_lo_i[4:0]));
            end
            IMM_PFX: begin
                if (PREFIX_EN != 0) begin
                    is_pfx_o = 1'b1;
                end else begin
                    illegal_o = 1'b1;
                end
            end
            default: illegal_o = 1'b1;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/imm_pipe_stage.sv
`default_nettype none
// ============================================================================
// imm_pipe_stage : one-deep immediate-generation pipeline stage with prefix
// Rev 1.0
// ============================================================================
module imm_pipe_stage
    import imm_pipe_stage_pkg::*;
#(
    parameter int INSTR_W   = 16,
    parameter int IMM_W     = 16,
    parameter int PREFIX_EN = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] instruction,
    input  logic [2:0]         imm_src,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [IMM_W-1:0]   imm_out,
    output logic [INSTR_W-1:0] instr_out,
    output logic               prefixed,
    output logic               illegal,
    output logic               dbl_prefix
);

    pfx_state_e         state_q,  state_d;
    logic [PFX_W-1:0]   prefix_q, prefix_d;
    logic               valid_q,  valid_d;
    logic [IMM_W-1:0]   imm_q,    imm_d;
    logic [INSTR_W-1:0] instr_q,  instr_d;
    logic               pfxd_q,   pfxd_d;
    logic               ill_q,    ill_d;
    logic               dbl_q,    dbl_d;

    logic [3:0]         w_raw_lo;
    logic [IMM_W-1:0]   w_ext;
    logic [IMM_W-1:0]   w_pfx_imm;
    logic [15:0]        w_pfx_cat;
    logic               w_is_pfx;
    logic               w_illegal;
    logic               w_xfer_in;
    logic               w_drain;

    imm_field_extract #(
        .IMM_W     (IMM_W),
        .PREFIX_EN (PREFIX_EN)
    ) u_extract (
        .instr_lo_i (instruction[PFX_W-1:0]),
        .imm_src_i  (imm_src),
        .raw_lo_o   (w_raw_lo),
        .ext_o      (w_ext),
        .is_pfx_o   (w_is_pfx),
        .illegal_o  (w_illegal)
    );

    assign in_ready  = !valid_q || out_ready;
    assign w_xfer_in = in_valid && in_ready;
    assign w_drain   = valid_q && out_ready;

    // Prefixed value is a 16-bit signed quantity; the size cast extends or truncates to IMM_W
    assign w_pfx_cat = {prefix_q, w_raw_lo};
    assign w_pfx_imm = IMM_W'($signed(w_pfx_cat));

    always_comb begin
        state_d  = state_q;
        prefix_d = prefix_q;
        valid_d  = valid_q;
        imm_d    = imm_q;
        instr_d  = instr_q;
        pfxd_d   = pfxd_q;
        ill_d    = ill_q;
        dbl_d    = 1'b0;
        if (flush) begin
            valid_d = 1'b0;
            state_d = ST_IDLE;
        end else if (w_xfer_in && w_is_pfx) begin
            // A prefix is absorbed; any result being drained this cycle leaves the register empty
            prefix_d = instruction[PFX_W-1:0];
            state_d  = ST_ARMED;
            dbl_d    = (state_q == ST_ARMED);
            valid_d  = 1'b0;
        end else if (w_xfer_in) begin
            valid_d = 1'b1;
            instr_d = instruction;
            ill_d   = w_illegal;
            state_d = ST_IDLE;
            if (w_illegal) begin
                imm_d  = '0;
                pfxd_d = 1'b0;
            end else if (state_q == ST_ARMED) begin
                imm_d  = w_pfx_imm;
                pfxd_d = 1'b1;
            end else begin
                imm_d  = w_ext;
                pfxd_d = 1'b0;
            end
        end else if (w_drain) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            prefix_q <= '0;
            valid_q  <= 1'b0;
            imm_q    <= '0;
            instr_q  <= '0;
            pfxd_q   <= 1'b0;
            ill_q    <= 1'b0;
            dbl_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            prefix_q <= prefix_d;
            valid_q  <= valid_d;
            imm_q    <= imm_d;
            instr_q  <= instr_d;
            pfxd_q   <= pfxd_d;
            ill_q    <= ill_d;
            dbl_q    <= dbl_d;
        end
    end

    assign out_valid  = valid_q;
    assign imm_out    = imm_q;
    assign instr_out  = instr_q;
    assign prefixed   = pfxd_q;
    assign illegal    = ill_q;
    assign dbl_prefix = dbl_q;

endmodule
`default_nettype wire

// File: tb/tb_imm_pipe_stage.sv
`default_nettype none
// ============================================================================
// tb_imm_pipe_stage : directed + random bench against an arithmetic reference
// Rev 1.0
// ============================================================================
module tb_imm_pipe_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] instruction;
    logic [2:0]  imm_src;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] imm_out;
    logic [15:0] instr_out;
    logic        prefixed;
    logic        illegal;
    logic        dbl_prefix;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference state: what the output side should show, plus the pending prefix
    bit          m_valid, m_armed, m_dbl, m_pre, m_ill;
    logic [11:0] m_pfx;
    logic [15:0] m_imm, m_instr;

    always #5 clk = ~clk;

    imm_pipe_stage #(
        .INSTR_W   (16),
        .IMM_W     (16),
        .PREFIX_EN (1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .instruction (instruction),
        .imm_src     (imm_src),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .imm_out     (imm_out),
        .instr_out   (instr_out),
        .prefixed    (prefixed),
        .illegal     (illegal),
        .dbl_prefix  (dbl_prefix)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        m_valid = 0; m_armed = 0; m_dbl = 0; m_pre = 0; m_ill = 0;
        m_pfx = '0; m_imm = '0; m_instr = '0;
    endtask

    task automatic model_edge(input bit v, input logic [15:0] ins, input logic [2:0] src,
                              input bit ordy, input bit fl);
        int val  = 0;
        int low4 = 0;
        bit acc;
        if (fl) begin
            m_valid = 0; m_armed = 0; m_dbl = 0;
            return;
        end
        m_dbl = 0;
        acc = v && (!m_valid || ordy);
        if (!acc) begin
            if (ordy) m_valid = 0;
            return;
        end
        if (src == 3'd4) begin
            m_dbl = m_armed; m_armed = 1; m_pfx = ins[11:0]; m_valid = 0;
            return;
        end
        m_valid = 1; m_instr = ins; m_ill = 0; m_pre = 0;
        case (src)
            3'd0: begin val = ins[11:4]; low4 = ins[7:4]; end
            3'd1: begin val = ins[5:0]; if (val >= 32) val -= 64; low4 = ins[3:0]; end
            3'd2: begin val = ins[5:3]; low4 = val; end
            3'd3: begin val = ins[4:0]; if (val >= 16) val -= 32; low4 = ins[3:0]; end
            default: m_ill = 1;
        endcase
        if (m_ill) begin
            m_imm = '0;
        end else if (m_armed) begin
            val = m_pfx * 16 + low4;
            if (val >= 32768) val -= 65536;
            m_imm = val[15:0];
            m_pre = 1;
        end else begin
            m_imm = val[15:0];
        end
        m_armed = 0;
    endtask

    task automatic check_outputs();
        check("out_valid", out_valid, m_valid);
        check("dbl_prefix", dbl_prefix, m_dbl);
        if (m_valid) begin
            check("imm_out", imm_out, m_imm);
            check("instr_out", instr_out, m_instr);
            check("prefixed", prefixed, m_pre);
            check("illegal", illegal, m_ill);
        end
    endtask

    task automatic step(input bit v, input logic [15:0] ins, input logic [2:0] src,
                        input bit ordy, input bit fl);
        in_valid = v; instruction = ins; imm_src = src; out_ready = ordy; flush = fl;
        #1;
        check("in_ready", in_ready, !m_valid || ordy);
        @(posedge clk);
        model_edge(v, ins, src, ordy, fl);
        #1;
        check_outputs();
    endtask

    task automatic check_reset_zero(input string tag);
        check({tag, ".out_valid"}, out_valid, 0);
        check({tag, ".imm_out"}, imm_out, 0);
        check({tag, ".instr_out"}, instr_out, 0);
        check({tag, ".prefixed"}, prefixed, 0);
        check({tag, ".illegal"}, illegal, 0);
        check({tag, ".dbl_prefix"}, dbl_prefix, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b1; in_valid = 0; instruction = '0; imm_src = '0; flush = 0; out_ready = 0;
        #2 rst_n = 1'b0;
        #1 check_reset_zero("reset");
        model_reset();
        @(posedge clk); @(posedge clk);
        #1 rst_n = 1'b1;

        step(1, 16'h0A5C, 3'd0, 1, 0);
        check("u8", imm_out, 16'h00A5);
        check("u8.prefixed", prefixed, 0);
        step(1, 16'h003F, 3'd1, 1, 0);
        check("s6", imm_out, 16'hFFFF);
        step(1, 16'h0010, 3'd3, 1, 0);
        check("s5", imm_out, 16'hFFF0);

        step(1, 16'h0123, 3'd4, 1, 0);
        check("pfx.no_out", out_valid, 0);
        step(1, 16'h0007, 3'd3, 1, 0);
        check("pfx.imm", imm_out, 16'h1237);
        check("pfx.prefixed", prefixed, 1);
        step(0, 16'h0000, 3'd0, 1, 0);
        check("pfx.single", out_valid, 0);

        step(1, 16'h0111, 3'd4, 1, 0);
        step(1, 16'h0FFF, 3'd4, 1, 0);
        check("dbl.pulse", dbl_prefix, 1);
        step(1, 16'h0002, 3'd3, 1, 0);
        check("dbl.clear", dbl_prefix, 0);
        check("dbl.imm", imm_out, 16'hFFF2);

        step(1, 16'h0A5C, 3'd0, 1, 0);
        for (int i = 0; i < 3; i++) begin
            step(1, 16'h0031, 3'd1, 0, 0);
            check("stall.in_ready", in_ready, 0);
            check("stall.imm", imm_out, 16'h00A5);
        end
        step(1, 16'h0031, 3'd1, 1, 0);
        check("stall.second", imm_out, 16'hFFF1);
        step(0, 16'h0000, 3'd0, 1, 0);

        step(1, 16'h0A5C, 3'd0, 1, 0);
        step(1, 16'h0123, 3'd4, 1, 0);
        step(1, 16'h0456, 3'd4, 1, 0);
        #1 rst_n = 1'b0;
        #1 check_reset_zero("armed_reset");
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
        step(1, 16'h0007, 3'd3, 1, 0);
        check("post_reset.imm", imm_out, 16'h0007);
        check("post_reset.prefixed", prefixed, 0);
        step(1, 16'h1234, 3'd6, 1, 0);
        check("illegal.flag", illegal, 1);
        check("illegal.imm", imm_out, 16'h0000);

        for (int i = 0; i < 400; i++) begin
            logic [15:0] r_ins;
            logic [2:0]  r_src;
            r_ins = 16'($urandom);
            r_src = ($urandom_range(0, 3) == 0) ? 3'd4 : 3'($urandom);
            step(($urandom_range(0, 3) != 0), r_ins, r_src,
                 ($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0));
        end
        step(0, 16'h0000, 3'd0, 1, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
